// File: rtl/br_rs.sv
// In-order branch reservation station: circular queue of DEPTH entries with CDB wakeup.
// Optional BR_RS_PERF_EN adds hierarchy-only stall/wait performance counters.
package br_rs_pkg;
  localparam int unsigned BR_PRF_IDX_W = 6;
  localparam int unsigned BR_ROB_IDX_W = 5;
  localparam int unsigned BR_OPC_W     = 4;

  typedef struct packed {
    logic [BR_ROB_IDX_W-1:0] rob_id;
    logic [4:0]              rd_arch;
    logic [BR_PRF_IDX_W-1:0] rd_phy;
    logic [BR_OPC_W-1:0]     fu_opcode;
    logic [31:0]             pc;
    logic [31:0]             imm;
    logic                    predict_taken;
    logic [31:0]             predict_target;
    logic [BR_PRF_IDX_W-1:0] rs1_phy;
    logic [BR_PRF_IDX_W-1:0] rs2_phy;
  } br_uop_t;

  typedef struct packed {
    br_uop_t     uop;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
  } fu_br_reg_t;
endpackage

module br_rs #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_CDB   = 4,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      backend_flush,
  input  logic                      dispatch_valid,
  output logic                      dispatch_ready,
  input  br_rs_pkg::br_uop_t        dispatch_uop,
  input  logic                      rs1_ready_in,
  input  logic                      rs2_ready_in,
  input  logic [31:0]               rs1_value_in,
  input  logic [31:0]               rs2_value_in,
  input  logic                      cdb_valid    [NUM_CDB],
  input  logic [PRF_IDX_W-1:0]      cdb_rd_phy   [NUM_CDB],
  input  logic [31:0]               cdb_rd_value [NUM_CDB],
  output logic                      br_rs_valid,
  input  logic                      fu_br_ready,
  output br_rs_pkg::fu_br_reg_t     fu_br_reg_in
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  // The payload struct widths are fixed by the package, so the parameters must agree.
  if (PRF_IDX_W != br_rs_pkg::BR_PRF_IDX_W || ROB_IDX_W != br_rs_pkg::BR_ROB_IDX_W) begin : g_width_check
    $error("br_rs: PRF_IDX_W/ROB_IDX_W must match br_rs_pkg");
  end

  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count;
  br_rs_pkg::br_uop_t payload [DEPTH];
  logic [DEPTH-1:0]   rs1_rdy, rs2_rdy;
  logic [31:0]        rs1_val [DEPTH];
  logic [31:0]        rs2_val [DEPTH];

  logic               full, do_dispatch, do_issue;
  logic [32:0]        rs1_cap, rs2_cap;
  logic [DEPTH-1:0]   occ, wake1, wake2;
  logic [31:0]        wake1_val [DEPTH];
  logic [31:0]        wake2_val [DEPTH];

  // Returns {hit, value}; scanning downwards lets the lowest matching port win.
  function automatic logic [32:0] cdb_lookup(input logic [PRF_IDX_W-1:0] tag);
    logic [32:0] r;
    r = '0;
    for (int unsigned p = NUM_CDB; p > 0; p--) begin
      if (cdb_valid[p-1] && cdb_rd_phy[p-1] == tag) r = {1'b1, cdb_rd_value[p-1]};
    end
    return r;
  endfunction

  function automatic logic [32:0] capture(input logic [PRF_IDX_W-1:0] phy, input logic rdy,
                                          input logic [31:0] val);
    if (phy == '0) return {1'b1, 32'd0};
    if (rdy)       return {1'b1, val};
    return cdb_lookup(phy);
  endfunction

  assign full           = (count == (PTR_W+1)'(DEPTH));
  assign dispatch_ready = !full;
  assign br_rs_valid    = (count != '0) && rs1_rdy[head] && rs2_rdy[head];
  assign do_dispatch    = dispatch_valid && dispatch_ready && !backend_flush;
  assign do_issue       = br_rs_valid && fu_br_ready && !backend_flush;

  always_comb begin
    fu_br_reg_in.uop       = payload[head];
    fu_br_reg_in.rs1_value = rs1_val[head];
    fu_br_reg_in.rs2_value = rs2_val[head];
  end

  always_comb begin : comb_wake
    logic [PTR_W-1:0] off;
    logic [32:0]      m1, m2;
    rs1_cap = capture(dispatch_uop.rs1_phy, rs1_ready_in, rs1_value_in);
    rs2_cap = capture(dispatch_uop.rs2_phy, rs2_ready_in, rs2_value_in);
    occ   = '0;
    wake1 = '0;
    wake2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - head;
      occ[i]       = ({1'b0, off} < count);
      m1           = cdb_lookup(payload[i].rs1_phy);
      m2           = cdb_lookup(payload[i].rs2_phy);
      wake1[i]     = occ[i] && !rs1_rdy[i] && m1[32];
      wake2[i]     = occ[i] && !rs2_rdy[i] && m2[32];
      wake1_val[i] = m1[31:0];
      wake2_val[i] = m2[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
    end else if (backend_flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wake1[i]) rs1_rdy[i] <= 1'b1;
        if (wake2[i]) rs2_rdy[i] <= 1'b1;
      end
      if (do_dispatch) begin
        rs1_rdy[tail] <= rs1_cap[32];
        rs2_rdy[tail] <= rs2_cap[32];
        tail          <= tail + 1'b1;
      end
      if (do_issue) head <= head + 1'b1;
      case ({do_dispatch, do_issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload and operand values are don't-care while an entry is empty, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wake1[i]) rs1_val[i] <= wake1_val[i];
      if (wake2[i]) rs2_val[i] <= wake2_val[i];
    end
    if (do_dispatch) begin
      payload[tail] <= dispatch_uop;
      rs1_val[tail] <= rs1_cap[31:0];
      rs2_val[tail] <= rs2_cap[31:0];
    end
  end

`ifdef BR_RS_PERF_EN
  logic [31:0] perf_full_stall_cnt;
  logic [31:0] perf_head_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_stall_cnt <= '0;
      perf_head_wait_cnt  <= '0;
    end else begin
      if (dispatch_valid && !dispatch_ready) perf_full_stall_cnt <= perf_full_stall_cnt + 1'b1;
      if (count != '0 && !br_rs_valid)       perf_head_wait_cnt  <= perf_head_wait_cnt + 1'b1;
    end
  end
`else
  // Performance counters are compiled out; behaviour is identical.
`endif

endmodule

// File: tb/tb_br_rs.sv
// Self-checking bench for br_rs: scoreboard of expected issues popped by an issue monitor.
module tb_br_rs;
  import br_rs_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned NUM_CDB   = 4;
  localparam int unsigned PRF_IDX_W = 6;
  localparam int unsigned ROB_IDX_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 backend_flush = 1'b0;
  logic                 dispatch_valid = 1'b0;
  logic                 dispatch_ready;
  br_uop_t              dispatch_uop = '0;
  logic                 rs1_ready_in = 1'b0;
  logic                 rs2_ready_in = 1'b0;
  logic [31:0]          rs1_value_in = '0;
  logic [31:0]          rs2_value_in = '0;
  logic                 cdb_valid    [NUM_CDB];
  logic [PRF_IDX_W-1:0] cdb_rd_phy   [NUM_CDB];
  logic [31:0]          cdb_rd_value [NUM_CDB];
  logic                 br_rs_valid;
  logic                 fu_br_ready = 1'b0;
  fu_br_reg_t           fu_br_reg_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;

  br_rs #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .backend_flush(backend_flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_uop(dispatch_uop),
    .rs1_ready_in(rs1_ready_in), .rs2_ready_in(rs2_ready_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
    .br_rs_valid(br_rs_valid), .fu_br_ready(fu_br_ready), .fu_br_reg_in(fu_br_reg_in)
  );

  always #5 clk = ~clk;

  // Issue monitor: an issue happens at the next rising edge when these hold mid-cycle.
  always @(negedge clk) begin
    if (rst_n && !backend_flush && br_rs_valid && fu_br_ready) begin
      exp_t e;
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got pc=%h, want no issue", fu_br_reg_in.uop.pc);
      end else begin
        e = sb.pop_front();
        if (fu_br_reg_in.uop.pc !== e.pc || fu_br_reg_in.rs1_value !== e.v1 ||
            fu_br_reg_in.rs2_value !== e.v2) begin
          errors++;
          $display("FAIL issue_payload: got pc=%h rs1=%h rs2=%h, want pc=%h rs1=%h rs2=%h",
                   fu_br_reg_in.uop.pc, fu_br_reg_in.rs1_value, fu_br_reg_in.rs2_value,
                   e.pc, e.v1, e.v2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cdb();
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb_valid[p]    = 1'b0;
      cdb_rd_phy[p]   = '0;
      cdb_rd_value[p] = '0;
    end
  endtask

  task automatic set_cdb(input int port, input logic [PRF_IDX_W-1:0] tag, input logic [31:0] val);
    cdb_valid[port]    = 1'b1;
    cdb_rd_phy[port]   = tag;
    cdb_rd_value[port] = val;
  endtask

  // Offers a uop for one cycle; records the expectation only if it will be accepted.
  task automatic drive(input logic [31:0] pc,
                       input logic [PRF_IDX_W-1:0] p1, input logic r1, input logic [31:0] v1,
                       input logic [PRF_IDX_W-1:0] p2, input logic r2, input logic [31:0] v2,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    dispatch_uop                = '0;
    dispatch_uop.pc             = pc;
    dispatch_uop.rob_id         = pc[6:2];
    dispatch_uop.fu_opcode      = 4'h3;
    dispatch_uop.imm            = 32'h10;
    dispatch_uop.predict_target = pc + 32'h10;
    dispatch_uop.rs1_phy        = p1;
    dispatch_uop.rs2_phy        = p2;
    rs1_ready_in                = r1;
    rs1_value_in                = v1;
    rs2_ready_in                = r2;
    rs2_value_in                = v2;
    dispatch_valid              = 1'b1;
    if (dispatch_ready && !backend_flush) begin
      e.pc = pc; e.v1 = e1; e.v2 = e2;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fu_br_ready = 1'b0;
    clear_cdb();
    repeat (2) step();
    checks++; if (br_rs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", br_rs_valid); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", dispatch_ready); end
    checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count); end
    rst_n = 1'b1;
    step();
    drive(32'h80, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2, 32'h1, 32'h2);
    step();
    dispatch_valid = 1'b0;
    checks++; if (br_rs_valid !== 1'b1) begin errors++; $display("FAIL pre_async_valid: got %b want 1", br_rs_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (br_rs_valid !== 1'b0 || dut.count !== 4'd0) begin
      errors++; $display("FAIL async_reset: got valid=%b count=%0d want 0/0", br_rs_valid, dut.count);
    end
    sb.delete();
    step();
    rst_n = 1'b1;
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", dispatch_ready); end
  endtask

  task automatic test_ready_issue();
    int p0 = pops;
    fu_br_ready = 1'b1;
    drive(32'h100, 6'd3, 1'b1, 32'd5, 6'd4, 1'b1, 32'd5, 32'd5, 32'd5);
    step();
    dispatch_valid = 1'b0;
    checks++; if (br_rs_valid !== 1'b1) begin errors++; $display("FAIL beq_valid_next: got %b want 1", br_rs_valid); end
    step();
    checks++; if (dut.count !== 4'd0 || br_rs_valid !== 1'b0) begin
      errors++; $display("FAIL beq_drain: got count=%0d valid=%b want 0/0", dut.count, br_rs_valid);
    end
    checks++; if (pops !== p0 + 1) begin errors++; $display("FAIL beq_issues: got %0d want %0d", pops - p0, 1); end
  endtask

  task automatic test_cdb_wakeup();
    int p0 = pops;
    drive(32'h200, 6'd12, 1'b0, 32'hBAD, 6'd0, 1'b0, 32'h77, 32'hDEAD, 32'h0);
    step();
    dispatch_valid = 1'b0;
    checks++; if (br_rs_valid !== 1'b0) begin errors++; $display("FAIL bne_wait0: got %b want 0", br_rs_valid); end
    step();
    set_cdb(2, 6'd12, 32'hDEAD);
    checks++; if (br_rs_valid !== 1'b0) begin errors++; $display("FAIL bne_no_bypass: got %b want 0", br_rs_valid); end
    step();
    clear_cdb();
    checks++; if (br_rs_valid !== 1'b1) begin errors++; $display("FAIL bne_woken: got %b want 1", br_rs_valid); end
    step();
    checks++; if (pops !== p0 + 1 || dut.count !== 4'd0) begin
      errors++; $display("FAIL bne_drain: got issues=%0d count=%0d want 1/0", pops - p0, dut.count);
    end
  endtask

  task automatic test_in_order();
    int p0 = pops;
    int early = 0;
    drive(32'h300, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 32'h1234, 32'h0);
    step();
    drive(32'h304, 6'd7, 1'b1, 32'd7, 6'd8, 1'b1, 32'd8, 32'd7, 32'd8);
    step();
    dispatch_valid = 1'b0;
    repeat (3) begin
      if (br_rs_valid) early++;
      step();
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL blocked_head: got %0d valid cycles want 0", early); end
    set_cdb(0, 6'd9, 32'h1234);
    step();
    clear_cdb();
    checks++; if (br_rs_valid !== 1'b1) begin errors++; $display("FAIL jal_issue: got %b want 1", br_rs_valid); end
    step();
    checks++; if (br_rs_valid !== 1'b1) begin errors++; $display("FAIL blt_next: got %b want 1", br_rs_valid); end
    step();
    checks++; if (pops !== p0 + 2 || br_rs_valid !== 1'b0) begin
      errors++; $display("FAIL order_drain: got issues=%0d valid=%b want 2/0", pops - p0, br_rs_valid);
    end
  endtask

  task automatic test_full_wrap();
    int   p0 = pops;
    int   refused = 0;
    int   gaps = 0;
    int   n = 0;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (dispatch_ready !== 1'b1) refused++;
      drive(32'h400 + 32'(4*i), 6'(20+i), 1'b0, 32'h0, 6'(40+i), 1'b1, 32'(i),
            32'h1000 + 32'(i), 32'(i));
      step();
    end
    checks++; if (refused !== 0) begin errors++; $display("FAIL fill_refused: got %0d want 0", refused); end
    drive(32'h440, 6'd30, 1'b1, 32'hA, 6'd31, 1'b1, 32'hB, 32'hA, 32'hB);
    checks++; if (dispatch_ready !== 1'b0 || dut.count !== 4'd8) begin
      errors++; $display("FAIL full: got ready=%b count=%0d want 0/8", dispatch_ready, dut.count);
    end
    step();
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", dispatch_ready); end
    for (int p = 0; p < 4; p++) set_cdb(p, 6'(20+p), 32'h1000 + 32'(p));
    step();
    if (!br_rs_valid) gaps++;
    for (int p = 0; p < 4; p++) set_cdb(p, 6'(24+p), 32'h1004 + 32'(p));
    step();
    if (!br_rs_valid) gaps++;
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL ninth_ready: got %b want 1", dispatch_ready); end
    e.pc = 32'h440; e.v1 = 32'hA; e.v2 = 32'hB;
    sb.push_back(e);
    clear_cdb();
    step();
    dispatch_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      if (!br_rs_valid) gaps++;
      step();
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL wrap_timeout: got %0d pending want 0", sb.size()); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL wrap_bubbles: got %0d want 0", gaps); end
    checks++; if (pops !== p0 + 9 || dut.count !== 4'd0) begin
      errors++; $display("FAIL wrap_issues: got issues=%0d count=%0d want 9/0", pops - p0, dut.count);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    fu_br_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(4*i), 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'(i), 32'(i), 32'(i));
      step();
    end
    dispatch_valid = 1'b0;
    checks++; if (dut.count !== 4'd3 || br_rs_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got count=%0d valid=%b want 3/1", dut.count, br_rs_valid);
    end
    fu_br_ready   = 1'b1;
    backend_flush = 1'b1;
    drive(32'h5FC, 6'd1, 1'b1, 32'h55, 6'd2, 1'b1, 32'h66, 32'h55, 32'h66);
    step();
    backend_flush  = 1'b0;
    dispatch_valid = 1'b0;
    sb.delete();
    checks++; if (dut.count !== 4'd0 || br_rs_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got count=%0d valid=%b want 0/0", dut.count, br_rs_valid);
    end
    repeat (4) begin
      if (br_rs_valid) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_ghost: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_same_cycle_capture();
    int p0 = pops;
    fu_br_ready = 1'b1;
    drive(32'h600, 6'd5, 1'b1, 32'h22, 6'd14, 1'b0, 32'hBAD, 32'h22, 32'h40);
    set_cdb(1, 6'd14, 32'h40);
    set_cdb(3, 6'd5, 32'h99);
    step();
    clear_cdb();
    dispatch_valid = 1'b0;
    checks++; if (br_rs_valid !== 1'b1) begin errors++; $display("FAIL capture_valid: got %b want 1", br_rs_valid); end
    step();
    checks++; if (pops !== p0 + 1 || dut.count !== 4'd0) begin
      errors++; $display("FAIL capture_drain: got issues=%0d count=%0d want 1/0", pops - p0, dut.count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_cdb();
    test_reset();
    test_ready_issue();
    test_cdb_wakeup();
    test_in_order();
    test_full_wrap();
    test_flush();
    test_same_cycle_capture();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/br_rs.md
# br_rs

In-order branch reservation station feeding `fu_br`. Accepts dispatched branch/jump/AUIPC uops from rename/dispatch into a circular queue of `DEPTH` entries. Each entry captures its source operands from the register file at dispatch or from CDB wakeup. The head entry is issued to `fu_br` once both operands are ready. Issue is strictly in program order, so branch resolution order matches fetch order.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `NUM_CDB`, 4: CDB broadcast ports snooped for wakeup.
- `PRF_IDX_W`, 6: physical register index width.
- `ROB_IDX_W`, 5: ROB id width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `backend_flush`  in  1  synchronous flush; squashes every entry.
- `dispatch_valid`  in  1  dispatch offers a uop.
- `dispatch_ready`  out  1  queue can accept; equals `!full` of the registered count.
- `dispatch_uop`  in  struct  `rob_id`, `rd_arch`, `rd_phy`, `fu_opcode`, `pc`, `imm`, `predict_taken`, `predict_target`, `rs1_phy`, `rs2_phy`.
- `rs1_ready_in`, `rs2_ready_in`  in  1 each  source already valid in the PRF at dispatch.
- `rs1_value_in`, `rs2_value_in`  in  32 each  PRF read data; meaningful only when the matching ready is set.
- `cdb_valid[NUM_CDB]`  in  1 each  broadcast valid.
- `cdb_rd_phy[NUM_CDB]`  in  PRF_IDX_W  broadcast tag.
- `cdb_rd_value[NUM_CDB]`  in  32  broadcast data.
- `br_rs_valid`  out  1  issue valid to `fu_br`.
- `fu_br_ready`  in  1  `fu_br` accepts.
- `fu_br_reg_in`  out  fu_br_reg_t  head entry payload: operands plus the dispatch fields.

## Operation
- Storage:
  - Per-entry payload, `rs1_rdy`, `rs2_rdy`, and the two 32-bit values.
  - Head and tail pointers of `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
  - `count` of `$clog2(DEPTH)+1` bits.
- Dispatch:
  - A write happens when `dispatch_valid && dispatch_ready`; the uop is written at `tail` and `tail` increments.
  - Operand capture priority: ready-at-dispatch value first, then a same-cycle CDB tag match, otherwise not ready.
  - Physical register 0 is always treated as ready with value 0.
- Wakeup:
  - Every cycle, each valid, not-ready operand of each occupied entry is compared against all CDB ports. On a match, the value is latched and the ready bit is set.
  - If multiple ports match the same tag, the lowest index wins. Only one match is legal.
- Issue:
  - `br_rs_valid = (count != 0) && head.rs1_rdy && head.rs2_rdy`. This uses registered ready bits only; there is no CDB bypass to the issue port.
  - On `br_rs_valid && fu_br_ready`, `head` increments.
  - Entries behind a non-ready head never issue.
- Count:
  - `+1` on dispatch, `-1` on issue; unchanged when both occur.
  - `dispatch_ready` is low whenever `count == DEPTH`, even if an issue happens the same cycle.
- Flush: `backend_flush` clears head, tail, count and all ready bits next edge, and blocks any dispatch or issue in that cycle from taking effect.
- Payload contents of empty entries are don't-care; only the ready bits are reset.

## Timing
- Reset (`rst_n` low, asynchronous): head = tail = count = 0, all ready bits 0, `br_rs_valid` = 0, `dispatch_ready` = 1.
- Minimum dispatch-to-issue latency is 1 cycle. A uop dispatched with both sources ready at edge N drives `br_rs_valid` in cycle N+1.
- Operand woken by CDB in cycle N: the ready bit is set at edge N+1, and the earliest issue is cycle N+1.
- Throughput is one issue and one dispatch per cycle.
- Pointer wrap from DEPTH-1 to 0 has no bubble.
- `rst_n` deassertion is synchronized externally. The first dispatch is accepted in the first cycle after deassertion.

## Configuration
- `BR_RS_PERF_EN`:
  - Defined: adds two 32-bit counters reset by `rst_n` and not by flush.
    - `perf_full_stall_cnt` increments on each cycle with `dispatch_valid && !dispatch_ready`.
    - `perf_head_wait_cnt` increments on each cycle with `count != 0 && !br_rs_valid`.
    - Both are readable only through hierarchy; there are no extra ports.
  - Undefined: the counters are absent, and there is no functional difference.

## Test plan
- Reset, then dispatch BEQ with rs1 = rs2 = ready, value 5 -> `br_rs_valid` = 1 the next cycle with rs1_value = rs2_value = 5; count returns to 0 after issue.
- Dispatch BNE with rs1 not ready (phy 12), then CDB broadcasts phy 12 = 0xDEAD two cycles later -> `br_rs_valid` rises the cycle after the broadcast with rs1_value = 0xDEAD.
- Dispatch JAL A (rs1 pending on phy 9), then BLT B (all ready) -> B must not issue before A. Broadcast phy 9 -> A issues, then B in the next cycle.
- Fill 8 entries, all not ready, with `dispatch_valid` held -> `dispatch_ready` = 0. Wake all entries -> 8 consecutive issues, tail/head wrap, 9th uop accepted, order preserved.
- With 3 entries, assert `backend_flush` in the same cycle as a dispatch and a head issue -> next cycle count = 0, `br_rs_valid` = 0, and the flushed uop never appears.
- Dispatch with rs2_phy = 14 not ready while the CDB broadcasts phy 14 = 0x40 in the same cycle -> the entry is stored ready with 0x40 and issues the next cycle.
